prv32_alu_arbiter: RTL and testbench

Shares a single `prv32_ALU` instance between two requesters (port 0: main execute path, port 1: auxiliary unit such as address/branch-compare or a multi-cycle sequencer). It performs round-robin or fixed-priority arbitration with valid/ready handshakes. The granted operation is computed combinationally and its result plus flags are captured in one registered response stage tagged with the requester ID. It sits between the execute-stage control and the ALU, and owns the ALU's operand, `alufn`, `shamt` and `opcode_5` inputs.

---
 rtl/prv32_alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_prv32_alu_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prv32_alu_arbiter.sv
// Two-port arbiter in front of a single shared RV32 ALU.
// Port 0 is the main execute path and port 1 is the auxiliary unit.
// The granted operation is evaluated combinationally. Its result, flags
// and requester id are captured in one registered response slot.
module prv32_alu_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic [3:0]       req0_alufn,
  input  logic             req0_op5,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [4:0]       req1_shamt,
  input  logic [3:0]       req1_alufn,
  input  logic             req1_op5,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_r,
  output logic             rsp_cf,
  output logic             rsp_zf,
  output logic             rsp_vf,
  output logic             rsp_sf,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              vld_p1;
  logic              rsp_id_p1;
  logic [31:0]       rsp_r_p1;
  logic              rsp_cf_p1, rsp_zf_p1, rsp_vf_p1, rsp_sf_p1;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;
  logic              last_grant;

  logic              slot_free;
  logic              grant;
  logic              accept_p0;
  logic signed [31:0] alu_a_p0, alu_b_p0;
  logic [4:0]        alu_shamt_p0;
  logic [3:0]        alu_fn_p0;
  logic              alu_op5_p0;
  logic [4:0]        sh_p0;
  logic [31:0]       opb_p0;
  logic [31:0]       add_p0;
  logic [31:0]       r_p0;
  logic              cf_p0, zf_p0, vf_p0, sf_p0;

  // ---- stage p0: arbitration, operand mux and ALU evaluation ----

  // Pick a winner; on a conflict round-robin favours the port not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign slot_free  = ~vld_p1 | rsp_ready;
  assign req0_ready = rst_n & slot_free & ~grant;
  assign req1_ready = rst_n & slot_free &  grant;
  assign accept_p0  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Route the granted port's operands to the ALU (port 0 when idle).
  always_comb begin
    alu_a_p0     = req0_a;
    alu_b_p0     = req0_b;
    alu_shamt_p0 = req0_shamt;
    alu_fn_p0    = req0_alufn;
    alu_op5_p0   = req0_op5;
    if (grant) begin
      alu_a_p0     = req1_a;
      alu_b_p0     = req1_b;
      alu_shamt_p0 = req1_shamt;
      alu_fn_p0    = req1_alufn;
      alu_op5_p0   = req1_op5;
    end
  end

  // Shared ALU: adder/subtractor drives the flags for every function.
  always_comb begin
    sh_p0  = alu_op5_p0 ? alu_b_p0[4:0] : alu_shamt_p0;
    opb_p0 = alu_fn_p0[0] ? ~alu_b_p0 : alu_b_p0;
    {cf_p0, add_p0} = {1'b0, alu_a_p0} + {1'b0, opb_p0} + {32'd0, alu_fn_p0[0]};
    zf_p0  = (add_p0 == 32'd0);
    sf_p0  = add_p0[31];
    vf_p0  = (alu_a_p0[31] == opb_p0[31]) && (add_p0[31] != alu_a_p0[31]);
    r_p0   = 32'd0;
    case (alu_fn_p0)
      ALU_ADD, ALU_SUB: r_p0 = add_p0;
      ALU_PASS:         r_p0 = alu_b_p0;
      ALU_OR:           r_p0 = alu_a_p0 | alu_b_p0;
      ALU_AND:          r_p0 = alu_a_p0 & alu_b_p0;
      ALU_XOR:          r_p0 = alu_a_p0 ^ alu_b_p0;
      ALU_SRL:          r_p0 = alu_a_p0 >> sh_p0;
      ALU_SRA:          r_p0 = alu_a_p0 >>> sh_p0;
      ALU_SLL:          r_p0 = alu_a_p0 << sh_p0;
      ALU_SLT:          r_p0 = {31'd0, sf_p0 ^ vf_p0};
      ALU_SLTU:         r_p0 = {31'd0, ~cf_p0};
      default:          r_p0 = 32'd0;
    endcase
  end

  // ---- stage p1: registered response slot ----

  // Response valid, arbitration history and grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      last_grant <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      last_grant <= grant;
      if (grant) cnt1_q <= sat_inc(cnt1_q);
      else       cnt0_q <= sat_inc(cnt0_q);
    end else if (rsp_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  // Response payload is captured only on accept and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_p1 <= 1'b0;
      rsp_r_p1  <= 32'd0;
      rsp_cf_p1 <= 1'b0;
      rsp_zf_p1 <= 1'b0;
      rsp_vf_p1 <= 1'b0;
      rsp_sf_p1 <= 1'b0;
    end else if (accept_p0) begin
      rsp_id_p1 <= grant;
      rsp_r_p1  <= r_p0;
      rsp_cf_p1 <= cf_p0;
      rsp_zf_p1 <= zf_p0;
      rsp_vf_p1 <= vf_p0;
      rsp_sf_p1 <= sf_p0;
    end
  end

  assign rsp_valid  = vld_p1;
  assign rsp_id     = rsp_id_p1;
  assign rsp_r      = rsp_r_p1;
  assign rsp_cf     = rsp_cf_p1;
  assign rsp_zf     = rsp_zf_p1;
  assign rsp_vf     = rsp_vf_p1;
  assign rsp_sf     = rsp_sf_p1;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_prv32_alu_arbiter.sv
// Directed bench for prv32_alu_arbiter: a round-robin instance (16-bit
// counters) and a fixed-priority instance (2-bit counters) share stimulus.
module tb_prv32_alu_arbiter;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [3:0]  req0_alufn, req1_alufn;
  logic        req0_op5, req1_op5;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_r;
  logic        rsp_cf, rsp_zf, rsp_vf, rsp_sf;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic        req0_ready_f, req1_ready_f, rsp_valid_f, rsp_id_f;
  logic [31:0] rsp_r_f;
  logic        rsp_cf_f, rsp_zf_f, rsp_vf_f, rsp_sf_f;
  logic [1:0]  grant_cnt0_f, grant_cnt1_f;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prv32_alu_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_shamt(req0_shamt), .req0_alufn(req0_alufn), .req0_op5(req0_op5),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_shamt(req1_shamt), .req1_alufn(req1_alufn), .req1_op5(req1_op5),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_vf(rsp_vf), .rsp_sf(rsp_sf),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  prv32_alu_arbiter #(.FIXED_PRIO(1), .CNT_W(2)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_f), .req0_a(req0_a), .req0_b(req0_b),
    .req0_shamt(req0_shamt), .req0_alufn(req0_alufn), .req0_op5(req0_op5),
    .req1_valid(req1_valid), .req1_ready(req1_ready_f), .req1_a(req1_a), .req1_b(req1_b),
    .req1_shamt(req1_shamt), .req1_alufn(req1_alufn), .req1_op5(req1_op5),
    .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready), .rsp_id(rsp_id_f), .rsp_r(rsp_r_f),
    .rsp_cf(rsp_cf_f), .rsp_zf(rsp_zf_f), .rsp_vf(rsp_vf_f), .rsp_sf(rsp_sf_f),
    .grant_cnt0(grant_cnt0_f), .grant_cnt1(grant_cnt1_f)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_shamt = '0; req0_alufn = '0; req0_op5 = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_shamt = '0; req1_alufn = '0; req1_op5 = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset state, with a request already presented.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_alufn = ALU_ADD;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_cnt0", grant_cnt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready0", req0_ready, 1);
    cyc();
    chk("add_valid", rsp_valid, 1);
    chk("add_r", rsp_r, 32'd8);
    chk("add_id", rsp_id, 0);
    chk("add_zf", rsp_zf, 0);
    chk("add_cnt0", grant_cnt0, 1);
    req0_valid = 1'b0;
    cyc();
    chk("drain_valid", rsp_valid, 0);
    chk("drain_hold_r", rsp_r, 32'd8);

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r", rsp_r, 0);
    chk("arst_cnt0", grant_cnt0, 0);
    chk("arst_cnt0_f", grant_cnt0_f, 0);
    chk("arst_ready0", req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Conflict every cycle: round-robin alternates, fixed priority keeps port 0.
    req0_valid = 1'b1; req0_a = 32'd7;    req0_b = 32'd7;    req0_alufn = ALU_SUB;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_alufn = ALU_XOR;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0));
      chk("rr_ready1", req1_ready, (i % 2 == 1));
      chk("fp_ready1", req1_ready_f, 0);
      cyc();
      chk("rr_id", rsp_id, i % 2);
      chk("rr_r", rsp_r, (i % 2 == 1) ? 32'hFF : 32'h0);
      if (i % 2 == 0) chk("rr_zf", rsp_zf, 1);
      chk("rr_cnt0", grant_cnt0, i / 2 + 1);
      chk("rr_cnt1", grant_cnt1, (i + 1) / 2);
      chk("fp_id", rsp_id_f, 0);
      chk("fp_r", rsp_r_f, 32'h0);
    end
    chk("sat_cnt0_f", grant_cnt0_f, 3);
    chk("fp_cnt1_f", grant_cnt1_f, 0);

    // Backpressure: response held, no readies, then accept on the draining cycle.
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", req0_ready, 0);
    chk("bp_ready1", req1_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_r", rsp_r, 32'h0);
      chk("bp_ready0h", req0_ready, 0);
      chk("bp_ready1h", req1_ready, 0);
      chk("bp_cnt0", grant_cnt0, 3);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready1", req1_ready, 1);
    chk("bp_rel_ready0", req0_ready, 0);
    cyc();
    chk("bp_next_id", rsp_id, 1);
    chk("bp_next_r", rsp_r, 32'hFF);
    chk("bp_next_cnt1", grant_cnt1, 3);
    chk("sat_hold_cnt0_f", grant_cnt0_f, 3);
    chk("sat_rsp_id_f", rsp_id_f, 0);
    chk("sat_rsp_valid_f", rsp_valid_f, 1);

    // Shift amount select on port 1 alone.
    req0_valid = 1'b0;
    req1_a = 32'd1; req1_b = 32'd4; req1_shamt = 5'd9; req1_alufn = ALU_SLL; req1_op5 = 1'b1;
    cyc();
    chk("sll_b_r", rsp_r, 32'h10);
    chk("sll_b_id", rsp_id, 1);
    req1_op5 = 1'b0;
    cyc();
    chk("sll_shamt_r", rsp_r, 32'h200);
    req1_a = 32'h8000_0000; req1_shamt = 5'd4; req1_alufn = ALU_SRA;
    cyc();
    chk("sra_r", rsp_r, 32'hF800_0000);
    chk("sra_r_f", rsp_r_f, 32'hF800_0000);
    chk("sra_id_f", rsp_id_f, 1);

    // Signed compare on port 0: -1 < 1.
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_alufn = ALU_SLT;
    cyc();
    chk("slt_r", rsp_r, 32'd1);
    chk("slt_sf", rsp_sf, 1);
    chk("slt_id", rsp_id, 0);
    req0_valid = 1'b0;
    cyc();
    chk("idle_valid", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
